// File: rtl/seq_detect_if.sv
// Handshake, configuration and status bundle for the serial pattern detector session controller.
interface seq_detect_if #(
    parameter int PMAX = 8,
    parameter int CW   = 8,
    parameter int TW   = 16
);
    logic            start;
    logic            abort;
    logic [PMAX-1:0] cfg_pattern;
    logic [3:0]      cfg_len;
    logic [CW-1:0]   cfg_count;
    logic [TW-1:0]   cfg_timeout;
    logic            w;
    logic            busy;
    logic            z;
    logic            done;
    logic            timeout_flag;
    logic            err;
    logic [CW-1:0]   hit_count;

    modport master (
        output start, abort, cfg_pattern, cfg_len, cfg_count, cfg_timeout, w,
        input  busy, z, done, timeout_flag, err, hit_count
    );
    modport slave (
        input  start, abort, cfg_pattern, cfg_len, cfg_count, cfg_timeout, w,
        output busy, z, done, timeout_flag, err, hit_count
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Armed, bounded detection session around a programmable overlapping serial pattern matcher.
module seq_detect_ctrl #(
    parameter int PMAX = 8,
    parameter int CW   = 8,
    parameter int TW   = 16
) (
    input logic        clock,
    input logic        reset,
    seq_detect_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARM, SEARCH, DONE} state_t;

    localparam logic [CW-1:0] HMAX = '1;

    state_t          state, state_n;
    logic [PMAX-1:0] pat_q, pat_n, hist, hist_n, mask;
    logic [3:0]      len_q, len_n, fill, fill_n;
    logic [CW-1:0]   cnt_q, cnt_n, hits, hits_n;
    logic [TW-1:0]   tmo_q, tmo_n, timer, timer_n;
    logic            z_q, z_n, tof_q, tof_n, err_q, err_n, match;

    always_comb begin
        mask = '0;
        for (int i = 0; i < PMAX; i++) mask[i] = (i < int'(len_q));
    end

    always_comb begin
        state_n = state;
        pat_n   = pat_q;
        len_n   = len_q;
        cnt_n   = cnt_q;
        tmo_n   = tmo_q;
        hist_n  = hist;
        fill_n  = fill;
        timer_n = timer;
        hits_n  = hits;
        tof_n   = tof_q;
        err_n   = err_q;
        z_n     = 1'b0;
        match   = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                pat_n  = bus.cfg_pattern;
                len_n  = bus.cfg_len;
                cnt_n  = bus.cfg_count;
                tmo_n  = bus.cfg_timeout;
                tof_n  = 1'b0;
                err_n  = 1'b0;
                hits_n = '0;
                if (bus.cfg_len == 4'd0 || int'(bus.cfg_len) > PMAX ||
                    (bus.cfg_count == '0 && bus.cfg_timeout == '0)) begin
                    err_n   = 1'b1;
                    state_n = DONE;
                end else begin
                    state_n = ARM;
                end
            end
            ARM: begin
                hist_n  = '0;
                fill_n  = '0;
                timer_n = '0;
                state_n = SEARCH;
            end
            SEARCH: begin
                hist_n  = (hist << 1) | PMAX'(bus.w);
                fill_n  = (fill == len_q) ? fill : fill + 4'd1;
                timer_n = timer + TW'(1);
                // fill counts bits seen before this one; the new bit completes the window
                match   = ({1'b0, fill} + 5'd1 >= {1'b0, len_q}) &&
                          ((hist_n & mask) == (pat_q & mask));
                if (match) begin
                    z_n = 1'b1;
                    if (hits != HMAX) hits_n = hits + CW'(1);
                end
                if (match && cnt_q != '0 && hits_n == cnt_q) begin
                    state_n = DONE;
                end else if (tmo_q != '0 && timer_n == tmo_q) begin
                    tof_n   = 1'b1;
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // abort freezes status as it stood and drops any hit pulse in flight
        if (bus.abort) begin
            state_n = IDLE;
            z_n     = 1'b0;
            hits_n  = hits;
            tof_n   = tof_q;
            err_n   = err_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pat_q <= '0;
            len_q <= '0;
            cnt_q <= '0;
            tmo_q <= '0;
            hist  <= '0;
            fill  <= '0;
            timer <= '0;
            hits  <= '0;
            tof_q <= 1'b0;
            err_q <= 1'b0;
            z_q   <= 1'b0;
        end else begin
            state <= state_n;
            pat_q <= pat_n;
            len_q <= len_n;
            cnt_q <= cnt_n;
            tmo_q <= tmo_n;
            hist  <= hist_n;
            fill  <= fill_n;
            timer <= timer_n;
            hits  <= hits_n;
            tof_q <= tof_n;
            err_q <= err_n;
            z_q   <= z_n;
        end
    end

    assign bus.busy         = (state == ARM) || (state == SEARCH);
    assign bus.done         = (state == DONE);
    assign bus.z            = z_q;
    assign bus.timeout_flag = tof_q;
    assign bus.err          = err_q;
    assign bus.hit_count    = hits;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: queue-based session model checked every cycle, plus literal pins.
module tb_seq_detect_ctrl;
    localparam int PMAX = 8;
    localparam int CW   = 8;
    localparam int TW   = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;

    seq_detect_if #(.PMAX(PMAX), .CW(CW), .TW(TW)) bus ();
    seq_detect_ctrl #(.PMAX(PMAX), .CW(CW), .TW(TW)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int npass = 0;
    int ntot  = 0;

    // model: phase 0 idle, 1 arm, 2 search, 3 done
    int              ph = 0;
    bit              m_z = 0, m_tof = 0, m_err = 0;
    int              m_hits = 0;
    bit              rx[$];
    int              nsrch = 0;
    logic [PMAX-1:0] s_pat = '0;
    int              s_len = 0, s_cnt = 0, s_tmo = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        ph = 0; m_z = 0; m_tof = 0; m_err = 0; m_hits = 0; nsrch = 0;
        rx.delete();
    endtask

    task automatic model_step();
        bit hit;
        m_z = 0;
        if (bus.abort) begin
            ph = 0;
            return;
        end
        case (ph)
            0: if (bus.start) begin
                s_pat = bus.cfg_pattern;
                s_len = int'(bus.cfg_len);
                s_cnt = int'(bus.cfg_count);
                s_tmo = int'(bus.cfg_timeout);
                m_tof = 0; m_err = 0; m_hits = 0;
                if (s_len < 1 || s_len > PMAX || (s_cnt == 0 && s_tmo == 0)) begin
                    m_err = 1; ph = 3;
                end else ph = 1;
            end
            1: begin rx.delete(); nsrch = 0; ph = 2; end
            2: begin
                rx.push_back(bus.w);
                nsrch++;
                hit = (rx.size() >= s_len);
                if (hit)
                    for (int k = 0; k < s_len; k++)
                        if (rx[rx.size() - 1 - k] != s_pat[k]) hit = 0;
                if (hit) begin
                    m_z = 1;
                    if (m_hits < (1 << CW) - 1) m_hits++;
                end
                if (hit && s_cnt != 0 && m_hits == s_cnt) ph = 3;
                else if (s_tmo != 0 && nsrch == s_tmo) begin m_tof = 1; ph = 3; end
            end
            default: ph = 0;
        endcase
    endtask

    task automatic compare();
        chk("busy", bus.busy, (ph == 1 || ph == 2));
        chk("z", bus.z, m_z);
        chk("done", bus.done, (ph == 3));
        chk("timeout_flag", bus.timeout_flag, m_tof);
        chk("err", bus.err, m_err);
        chk("hit_count", bus.hit_count, m_hits);
    endtask

    task automatic step(input bit s, input bit a, input bit wb);
        bus.start = s; bus.abort = a; bus.w = wb;
        model_step();
        @(posedge clock); #1;
        compare();
        bus.start = 1'b0; bus.abort = 1'b0;
    endtask

    task automatic cfg(input logic [PMAX-1:0] p, input logic [3:0] l,
                       input logic [CW-1:0] c, input logic [TW-1:0] t);
        bus.cfg_pattern = p; bus.cfg_len = l; bus.cfg_count = c; bus.cfg_timeout = t;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_z"}, bus.z, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_tof"}, bus.timeout_flag, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_hits"}, bus.hit_count, 0);
    endtask

    initial begin
        int n;
        bit pat2[7] = '{1, 0, 1, 0, 1, 0, 1};
        bus.start = 0; bus.abort = 0; bus.w = 0;
        cfg(8'h00, 4'd0, 8'd0, 16'd0);
        #12;
        chk_all_zero("reset");
        reset = 1'b1;

        // 1) single 1011 hit; start during DONE ignored
        cfg(8'h0B, 4'd4, 8'd1, 16'd0);
        step(1, 0, 0); step(0, 0, 0);
        step(0, 0, 1); step(0, 0, 0); step(0, 0, 1); step(0, 0, 1);
        chk("t1_z", bus.z, 1);
        chk("t1_done", bus.done, 1);
        chk("t1_hits", bus.hit_count, 1);
        chk("t1_busy", bus.busy, 0);
        step(1, 0, 0);
        chk("t1_start_in_done", bus.busy, 0);
        step(0, 0, 0);

        // 2) overlapping 101 with timeout landing on the 3rd hit
        cfg(8'h05, 4'd3, 8'd0, 16'd7);
        step(1, 0, 0); step(0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, pat2[i]);
        chk("t2_hits", bus.hit_count, 3);
        chk("t2_tof", bus.timeout_flag, 1);
        chk("t2_done", bus.done, 1);
        step(0, 0, 0);

        // 3) pure timeout
        cfg(8'h0B, 4'd4, 8'd2, 16'd10);
        n = 1;
        step(1, 0, 0);
        while (!bus.done && n < 40) begin step(0, 0, 0); n++; end
        chk("t3_latency", n, 12);
        chk("t3_tof", bus.timeout_flag, 1);
        chk("t3_hits", bus.hit_count, 0);
        step(0, 0, 0);

        // 4) config errors
        cfg(8'h0B, 4'd0, 8'd1, 16'd0);
        step(1, 0, 0);
        chk("t4a_err", bus.err, 1); chk("t4a_done", bus.done, 1); chk("t4a_busy", bus.busy, 0);
        step(0, 0, 0);
        cfg(8'h0B, 4'd9, 8'd1, 16'd0);
        step(1, 0, 0);
        chk("t4b_err", bus.err, 1); chk("t4b_done", bus.done, 1);
        step(0, 0, 0);
        cfg(8'h0B, 4'd4, 8'd0, 16'd0);
        step(1, 0, 0);
        chk("t4c_err", bus.err, 1); chk("t4c_done", bus.done, 1);
        step(0, 0, 0);

        // 5) abort after one hit, start while busy ignored
        cfg(8'h03, 4'd2, 8'd5, 16'd0);
        step(1, 0, 0); step(0, 0, 0);
        step(0, 0, 1); step(0, 0, 1);
        chk("t5_z", bus.z, 1);
        step(1, 0, 0);
        chk("t5_busy_start", bus.busy, 1);
        step(0, 1, 0);
        chk("t5_busy", bus.busy, 0);
        chk("t5_hits", bus.hit_count, 1);
        chk("t5_done", bus.done, 0);
        step(0, 0, 0); step(0, 0, 0);

        // asynchronous reset mid-session
        cfg(8'h0B, 4'd4, 8'd1, 16'd0);
        step(1, 0, 0); step(0, 0, 0); step(0, 0, 1);
        #2 reset = 1'b0;
        #1 chk_all_zero("midrst");
        model_reset();
        #2 reset = 1'b1;
        step(0, 0, 0);

        // 6) final hit and timeout together: hit wins
        cfg(8'h01, 4'd1, 8'd3, 16'd3);
        step(1, 0, 0); step(0, 0, 0);
        step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
        chk("t6_tof", bus.timeout_flag, 0);
        chk("t6_hits", bus.hit_count, 3);
        chk("t6_done", bus.done, 1);
        step(0, 0, 0); step(0, 0, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
